uart_rx: RTL

- UART receive path; sits directly downstream of the baud clock generator and consumes its 16x oversample rate, delivered as a single-cycle tick enable on the system clock.
- Deserialises an asynchronous rxd line (8N1 by default, LSB first) into parallel bytes.
- Presents each byte on a valid/ready holding register, with framing and overrun error pulses.
- Entirely in the clk domain; no derived clocks.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding and baud-rate table
// used by both the receive path and the baud clock generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;

    localparam int BAUD_4800   = 4800;
    localparam int BAUD_9600   = 9600;
    localparam int BAUD_19200  = 19200;
    localparam int BAUD_38400  = 38400;
    localparam int BAUD_57600  = 57600;
    localparam int BAUD_115200 = 115200;
    localparam int BAUD_128000 = 128000;
    localparam int BAUD_MIN    = BAUD_4800;
    localparam int BAUD_MAX    = BAUD_128000;

    // Clock cycles between oversample ticks for a given system clock and baud.
    function automatic int tick_div(input int clk_hz, input int baud);
        return clk_hz / (baud * DEFAULT_OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Reset-to-one flop chain for bringing an idle-high async line into clk.
// Latency STAGES clks; no backpressure.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= '1;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop deserialiser, optional parity via UART_RX_PARITY_EN.
// Byte valid 1 clk after the stop-sample tick; held until rx_ready, new byte dropped (overrun_err) if still full.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rxs;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    rx_state_t            state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 stop_ok, stop_bad, byte_good, load;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_nxt, par_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit  <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_bit;
`endif
        if (rx_tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        tick_nxt  = '0;
                        state_nxt = START;
                    end
                end
                START: begin
                    if (tick_cnt == TICK_MID) begin
                        // A start bit that is high again at its centre was noise.
                        if (!rxs) begin
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                            state_nxt = DATA;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt  = '0;
                        shreg_nxt = {rxs, shreg[DATA_BITS-1:1]};
                        bit_nxt   = bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt  = '0;
                        par_nxt   = rxs;
                        state_nxt = STOP;
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
`endif
                STOP: begin
                    // Leave at the stop centre so a back-to-back start edge is caught.
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt  = '0;
                        state_nxt = IDLE;
                        stop_ok   = rxs;
                        stop_bad  = !rxs;
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_bad   = ((^shreg) ^ par_bit) != PARITY_ODD;
    assign byte_good = stop_ok && !par_bad;
`else
    assign byte_good = stop_ok;
`endif
    assign load = byte_good && (!rx_valid || rx_ready);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_err   <= stop_bad;
            overrun_err <= byte_good && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err  <= stop_ok && par_bad;
`endif
            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
